// File: rtl/pc_pkg.sv
// Shared operation encoding and priority decode for the PC / return-address-stack unit.
package pc_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_LOAD,
        OP_RET,
        OP_CALL,
        OP_BRANCH,
        OP_INC
    } pc_op_t;

    // Fixed priority: stall > enable > ret > call > branch > incPC > hold.
    function automatic pc_op_t pc_decode(input logic stall,
                                         input logic enable,
                                         input logic ret,
                                         input logic call,
                                         input logic branch,
                                         input logic inc_pc);
        pc_op_t op;
        if (stall)       op = OP_HOLD;
        else if (enable) op = OP_LOAD;
        else if (ret)    op = OP_RET;
        else if (call)   op = OP_CALL;
        else if (branch) op = OP_BRANCH;
        else if (inc_pc) op = OP_INC;
        else             op = OP_HOLD;
        return op;
    endfunction

endpackage

// File: rtl/pc_ras_stack.sv
// Circular return-address stack: pushing when full overwrites the oldest entry,
// popping when empty is ignored.
module pc_ras_stack #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         top_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = 1;
    localparam logic [PW:0]   CNT_ONE  = 1;
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    top_q, top_d;
    logic [PW:0]      count_q, count_d;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_FULL);
    assign count    = count_q;
    assign top_data = mem[top_q];

    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        if (push) begin
            // The pointer wraps, so a push when full lands on the oldest slot.
            top_d = top_q + PTR_ONE;
            if (!full) count_d = count_q + CNT_ONE;
        end else if (pop && !empty) begin
            top_d   = top_q - PTR_ONE;
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            top_q   <= '1;
            count_q <= '0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; only the pointer and count define validity.
    always_ff @(posedge clock) begin
        if (push) mem[top_d] <= push_data;
    end

endmodule

// File: rtl/pc_ras_unit.sv
// Program counter with absolute load, relative branch, stepped increment and a
// call/return address stack with sticky overflow/underflow flags.
module pc_ras_unit
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned      STEP      = 1,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic                           clock,
    input  logic                           clear,
    input  logic                           stall,
    input  logic                           enable,
    input  logic                           ret,
    input  logic                           call,
    input  logic                           branch,
    input  logic                           incPC,
    input  logic                           err_clr,
    input  logic [WIDTH-1:0]               BusMuxOut,
    output logic [WIDTH-1:0]               BusMuxIn,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_empty,
    output logic                           ras_full,
    output logic                           ras_overflow,
    output logic                           ras_underflow
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    pc_op_t           op;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push, pop;
    logic [WIDTH-1:0] ras_top;

    always_comb begin
        op = pc_decode(stall, enable, ret, call, branch, incPC);
    end

    assign push = (op == OP_CALL);
    assign pop  = (op == OP_RET);

    pc_ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_stack (
        .clock     (clock),
        .clear     (clear),
        .push      (push),
        .pop       (pop),
        .push_data (pc_q + STEP_W),
        .top_data  (ras_top),
        .count     (ras_count),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    always_comb begin
        pc_d = pc_q;
        unique case (op)
            OP_LOAD:   pc_d = BusMuxOut;
            OP_RET:    pc_d = ras_empty ? pc_q : ras_top;
            OP_CALL:   pc_d = BusMuxOut;
            OP_BRANCH: pc_d = pc_q + BusMuxOut;
            OP_INC:    pc_d = pc_q + STEP_W;
            default:   pc_d = pc_q;
        endcase
    end

    // Clear first, so a same-cycle error event still leaves its flag set.
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (err_clr && !stall) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (op == OP_CALL && ras_full)  ovf_d = 1'b1;
        if (op == OP_RET  && ras_empty) unf_d = 1'b1;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            pc_q  <= RESET_VAL;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign BusMuxIn      = pc_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Self-checking bench for pc_ras_unit: directed vector table, async reset checks
// and randomized traffic against a queue-based reference model.
module tb_pc_ras_unit;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned STEP  = 4;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RVAL  = 32'h100;

    // Command bits: {stall, enable, ret, call, branch, incPC, err_clr}
    localparam logic [6:0] S = 7'b1000000;
    localparam logic [6:0] E = 7'b0100000;
    localparam logic [6:0] R = 7'b0010000;
    localparam logic [6:0] C = 7'b0001000;
    localparam logic [6:0] B = 7'b0000100;
    localparam logic [6:0] I = 7'b0000010;
    localparam logic [6:0] X = 7'b0000001;

    logic        clock, clear;
    logic        stall, enable, ret, call, branch, incPC, err_clr;
    logic [31:0] BusMuxOut, BusMuxIn;
    logic [2:0]  ras_count;
    logic        ras_empty, ras_full, ras_overflow, ras_underflow;

    int tests = 0;
    int fails = 0;

    pc_ras_unit #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RVAL),
        .STEP      (STEP),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clock         (clock),
        .clear         (clear),
        .stall         (stall),
        .enable        (enable),
        .ret           (ret),
        .call          (call),
        .branch        (branch),
        .incPC         (incPC),
        .err_clr       (err_clr),
        .BusMuxOut     (BusMuxOut),
        .BusMuxIn      (BusMuxIn),
        .ras_count     (ras_count),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: PC value, stack as a queue (back = newest), sticky flags.
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    logic        m_ovf, m_unf;

    task automatic model_reset();
        m_pc  = RVAL;
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input logic [6:0] ops, input logic [31:0] bus);
        if (ops[6]) return;
        if (ops[0]) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (ops[5]) begin
            m_pc = bus;
        end else if (ops[4]) begin
            if (m_q.size() == 0) m_unf = 1'b1;
            else m_pc = m_q.pop_back();
        end else if (ops[3]) begin
            if (m_q.size() == DEPTH) begin
                m_q.delete(0);
                m_ovf = 1'b1;
            end
            m_q.push_back(m_pc + STEP);
            m_pc = bus;
        end else if (ops[2]) begin
            m_pc = m_pc + bus;
        end else if (ops[1]) begin
            m_pc = m_pc + STEP;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " pc"},        BusMuxIn,      m_pc);
        check({tag, " count"},     32'(ras_count), 32'(m_q.size()));
        check({tag, " empty"},     32'(ras_empty), 32'(m_q.size() == 0));
        check({tag, " full"},      32'(ras_full),  32'(m_q.size() == DEPTH));
        check({tag, " overflow"},  32'(ras_overflow),  32'(m_ovf));
        check({tag, " underflow"}, 32'(ras_underflow), 32'(m_unf));
    endtask

    task automatic drive(input string tag, input logic [6:0] ops, input logic [31:0] bus);
        @(negedge clock);
        {stall, enable, ret, call, branch, incPC, err_clr} = ops;
        BusMuxOut = bus;
        @(posedge clock);
        model_step(ops, bus);
        #1;
        check_model(tag);
    endtask

    // Asynchronous reset asserted mid-cycle, checked before the next clock edge.
    task automatic async_reset(input string tag);
        #2;
        {stall, enable, ret, call, branch, incPC, err_clr} = '0;
        clear = 1'b0;
        model_reset();
        #1;
        check_model(tag);
        @(negedge clock);
        clear = 1'b1;
    endtask

    typedef struct {
        logic [6:0]  ops;
        logic [31:0] bus;
        logic [31:0] pc;
        int          cnt;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [6:0] ops, input logic [31:0] bus,
                               input logic [31:0] pc, input int cnt,
                               input logic ovf, input logic unf);
        vec_t r;
        r.ops = ops; r.bus = bus; r.pc = pc; r.cnt = cnt; r.ovf = ovf; r.unf = unf;
        return r;
    endfunction

    task automatic apply_vec(input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        drive(tag, tbl[idx].ops, tbl[idx].bus);
        check({tag, " tbl_pc"},  BusMuxIn, tbl[idx].pc);
        check({tag, " tbl_cnt"}, 32'(ras_count), 32'(tbl[idx].cnt));
        check({tag, " tbl_ovf"}, 32'(ras_overflow), 32'(tbl[idx].ovf));
        check({tag, " tbl_unf"}, 32'(ras_underflow), 32'(tbl[idx].unf));
    endtask

    initial begin
        // Step after release of reset
        tbl.push_back(v(I, 0, 32'h104, 0, 0, 0));
        tbl.push_back(v(I, 0, 32'h108, 0, 0, 0));
        tbl.push_back(v(I, 0, 32'h10C, 0, 0, 0));
        // Branch and increment wrap
        tbl.push_back(v(E, 32'h10,       32'h10,       0, 0, 0));
        tbl.push_back(v(B, 32'hFFFFFFF8, 32'h08,       0, 0, 0));
        tbl.push_back(v(E, 32'hFFFFFFFE, 32'hFFFFFFFE, 0, 0, 0));
        tbl.push_back(v(I, 0,            32'h2,        0, 0, 0));
        // Nested call/ret
        tbl.push_back(v(E, 32'h20,  32'h20,  0, 0, 0));
        tbl.push_back(v(C, 32'h400, 32'h400, 1, 0, 0));
        tbl.push_back(v(C, 32'h800, 32'h800, 2, 0, 0));
        tbl.push_back(v(R, 0,       32'h404, 1, 0, 0));
        tbl.push_back(v(R, 0,       32'h24,  0, 0, 0));
        // Overflow then drain and underflow
        tbl.push_back(v(C, 32'h1000, 32'h1000, 1, 0, 0));
        tbl.push_back(v(C, 32'h2000, 32'h2000, 2, 0, 0));
        tbl.push_back(v(C, 32'h3000, 32'h3000, 3, 0, 0));
        tbl.push_back(v(C, 32'h4000, 32'h4000, 4, 0, 0));
        tbl.push_back(v(C, 32'h5000, 32'h5000, 4, 1, 0));
        tbl.push_back(v(R, 0, 32'h4004, 3, 1, 0));
        tbl.push_back(v(R, 0, 32'h3004, 2, 1, 0));
        tbl.push_back(v(R, 0, 32'h2004, 1, 1, 0));
        tbl.push_back(v(R, 0, 32'h1004, 0, 1, 0));
        tbl.push_back(v(R, 0, 32'h1004, 0, 1, 1));
        // Priority and stall
        tbl.push_back(v(E | C | I, 32'h50, 32'h50, 0, 1, 1));
        tbl.push_back(v(S | R, 0,      32'h50, 0, 1, 1));
        tbl.push_back(v(S | E, 32'h99, 32'h50, 0, 1, 1));
        tbl.push_back(v(S | C, 32'h77, 32'h50, 0, 1, 1));
        tbl.push_back(v(S | X, 0,      32'h50, 0, 1, 1));
        // Flag clear race
        tbl.push_back(v(X | R, 0, 32'h50, 0, 0, 1));
        tbl.push_back(v(X,     0, 32'h50, 0, 0, 0));
        // ret beats call; call beats branch
        tbl.push_back(v(C,         32'h600, 32'h600, 1, 0, 0));
        tbl.push_back(v(R | C | B, 32'h700, 32'h54,  0, 0, 0));
        tbl.push_back(v(C | B | I, 32'h900, 32'h900, 1, 0, 0));
        tbl.push_back(v(B,         32'h10,  32'h910, 1, 0, 0));
        tbl.push_back(v(R,         0,       32'h58,  0, 0, 0));

        clear = 1'b0;
        {stall, enable, ret, call, branch, incPC, err_clr} = '0;
        BusMuxOut = '0;
        model_reset();
        #12;
        check_model("reset");
        @(negedge clock);
        clear = 1'b1;

        for (int i = 0; i < 3; i++) apply_vec(i);
        async_reset("midreset");
        for (int i = 3; i < tbl.size(); i++) apply_vec(i);

        // Randomized traffic, with one asynchronous reset while the stack is in use
        for (int i = 0; i < 400; i++) begin
            logic [6:0] ops;
            ops[6] = ($urandom_range(0, 99) < 10);
            ops[5] = ($urandom_range(0, 99) < 10);
            ops[4] = ($urandom_range(0, 99) < 30);
            ops[3] = ($urandom_range(0, 99) < 30);
            ops[2] = ($urandom_range(0, 99) < 20);
            ops[1] = ($urandom_range(0, 99) < 40);
            ops[0] = ($urandom_range(0, 99) < 8);
            drive($sformatf("rnd%0d", i), ops, $urandom());
            if (i == 200) async_reset("rndreset");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
